// File: rtl/decoder_arbiter.sv
// Round-robin arbiter over 16 level-sensitive requesters with a bounded hold time,
// a one-cycle break-before-make gap, and a one-hot decoded grant.

module decoder_4to16 (
    input  logic        enable,
    input  logic [3:0]  in,
    output logic [15:0] out
);
    always_comb begin
        out = '0;
        if (enable) out[in] = 1'b1;
    end
endmodule

module decoder_arbiter #(
    parameter int MAX_HOLD = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] req,
    input  logic        done,
    output logic        grant_en,
    output logic [3:0]  grant_idx,
    output logic [15:0] grant,
    output logic        busy,
    output logic        forced_release
);
    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t      state;
    state_t      state_next;
    logic [3:0]  ptr;
    logic [7:0]  hold_cnt;
    logic        timeout_q;
    logic [3:0]  winner;
    logic        hold_last;
    logic        release_now;
    logic        timeout_only;

    // First set request bit at or after ptr, wrapping modulo 16.
    always_comb begin
        logic [3:0] cand;
        logic       found;
        winner = ptr;
        found  = 1'b0;
        cand   = ptr;
        for (int i = 0; i < 16; i++) begin
            cand = ptr + 4'(i);
            if (!found && req[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    assign hold_last    = (hold_cnt == HOLD_LAST);
    assign release_now  = !req[grant_idx] || done || hold_last;
    assign timeout_only = req[grant_idx] && !done && hold_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (|req) state_next = GRANT;
            GRANT:   if (release_now) state_next = GAP;
            GAP:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // timeout_q remembers why the last grant ended; it is only visible during GAP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_idx <= 4'd0;
            ptr       <= 4'd0;
            hold_cnt  <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        grant_idx <= winner;
                        hold_cnt  <= 8'd0;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        ptr       <= grant_idx + 4'd1;
                        timeout_q <= timeout_only;
                    end else begin
                        hold_cnt  <= hold_cnt + 8'd1;
                    end
                end
                GAP:     timeout_q <= 1'b0;
                default: timeout_q <= 1'b0;
            endcase
        end
    end

    always_comb begin
        grant_en       = (state == GRANT);
        busy           = (state != IDLE);
        forced_release = (state == GAP) && timeout_q;
    end

    decoder_4to16 u_dec (
        .enable (grant_en),
        .in     (grant_idx),
        .out    (grant)
    );
endmodule

// File: tb/tb_decoder_arbiter.sv
// Directed bench for decoder_arbiter: expected grant order is queued as stimulus is
// applied and popped when each grant appears; length, gap and release pulse are checked too.

module tb_decoder_arbiter;
    logic        clk;
    logic        rst;
    logic [15:0] req;
    logic        done;
    logic        grant_en;
    logic [3:0]  grant_idx;
    logic [15:0] grant;
    logic        busy;
    logic        forced_release;

    int errors = 0;
    int checks = 0;
    logic [3:0] exp_q[$];

    decoder_arbiter #(.MAX_HOLD(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .req            (req),
        .done           (done),
        .grant_en       (grant_en),
        .grant_idx      (grant_idx),
        .grant          (grant),
        .busy           (busy),
        .forced_release (forced_release)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("%s mismatch", tag);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_grant"},     grant,          32'h0);
        check({tag, "_grant_en"},  grant_en,       32'h0);
        check({tag, "_grant_idx"}, grant_idx,      32'h0);
        check({tag, "_busy"},      busy,           32'h0);
        check({tag, "_forced"},    forced_release, 32'h0);
    endtask

    // Pulse reset starting at a falling edge; outputs must clear before any rising edge.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_async");
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("rst_held");
        rst = 1'b0;
    endtask

    // Waits for a grant, compares it with the queue head, then follows it through GAP and IDLE.
    // rel_kind: 0 none, 1 assert done, 2 drop the owner's request, in grant cycle rel_at.
    task automatic serve(input int rel_at, input int rel_kind, input int exp_len,
                         input logic exp_forced, input int exp_wait);
        int         waited;
        int         len;
        logic [3:0] idx;
        logic [15:0] exp_g;
        waited = 0;
        while (grant_en !== 1'b1 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        check("grant_seen", grant_en, 32'h1);
        idx   = (exp_q.size() > 0) ? exp_q.pop_front() : 4'bx;
        exp_g = 16'h1 << idx;
        check("grant_vec", grant, exp_g);
        check("grant_idx", grant_idx, idx);
        if (exp_wait >= 0) check("wait_cycles", waited, exp_wait);
        len = 0;
        while (grant_en === 1'b1 && len < 300) begin
            len++;
            if (len == rel_at) begin
                if (rel_kind == 1) done = 1'b1;
                else if (rel_kind == 2) req[idx] = 1'b0;
            end
            @(negedge clk);
        end
        done = 1'b0;
        check("grant_len",  len,            exp_len);
        check("gap_busy",   busy,           32'h1);
        check("gap_grant",  grant,          32'h0);
        check("gap_idx",    grant_idx,      idx);
        check("gap_forced", forced_release, exp_forced);
        @(negedge clk);
        check("idle_busy",   busy,           32'h0);
        check("idle_grant",  grant_en,       32'h0);
        check("idle_forced", forced_release, 32'h0);
    endtask

    initial begin
        int waited;
        rst  = 1'b0;
        req  = 16'hFFFF;
        done = 1'b0;
        #1 rst = 1'b1;
        #1;
        check_reset_outputs("rst_initial");
        @(negedge clk);
        @(negedge clk);
        req = 16'h0000;
        rst = 1'b0;

        // Single requester released by done in its third cycle, then regranted.
        @(negedge clk);
        req = 16'h0020;
        exp_q.push_back(4'd5);
        serve(3, 1, 3, 1'b0, 1);
        exp_q.push_back(4'd5);
        serve(1, 1, 1, 1'b0, 1);
        req = 16'h0000;

        // Full request vector: timeout every grant, round-robin wraps 15 -> 0.
        do_reset();
        req = 16'hFFFF;
        for (int i = 0; i < 17; i++) exp_q.push_back(4'(i));
        for (int i = 0; i < 17; i++) serve(0, 0, 8, 1'b1, 1);
        req = 16'h0000;

        // Two requesters alternate.
        do_reset();
        req = 16'h1008;
        exp_q.push_back(4'd3);
        exp_q.push_back(4'd12);
        exp_q.push_back(4'd3);
        exp_q.push_back(4'd12);
        for (int i = 0; i < 4; i++) serve(2, 1, 2, 1'b0, 1);
        req = 16'h0000;

        // Request drop early, and done / drop coinciding with the hold limit.
        do_reset();
        req = 16'h0080;
        exp_q.push_back(4'd7);
        serve(2, 2, 2, 1'b0, 1);
        req = 16'h0080;
        exp_q.push_back(4'd7);
        serve(8, 1, 8, 1'b0, 1);
        exp_q.push_back(4'd7);
        serve(8, 2, 8, 1'b0, 1);
        req = 16'h0000;
        repeat (3) @(negedge clk);
        check("no_req_idle", grant_en, 32'h0);

        // Reset in the middle of a grant aborts it; next arbitration starts at 0.
        do_reset();
        req = 16'h0400;
        waited = 0;
        while (grant_en !== 1'b1 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        check("mid_grant_vec", grant, 32'h0400);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_mid");
        @(negedge clk);
        check("rst_mid_forced", forced_release, 32'h0);
        req = 16'h0401;
        rst = 1'b0;
        exp_q.push_back(4'd0);
        serve(0, 0, 8, 1'b1, 1);
        req = 16'h0000;

        check("queue_drained", exp_q.size(), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/decoder_arbiter.md
DECODER_ARBITER -- requirements
Module: decoder_arbiter

Interface
REQ-001 The block SHALL have parameter MAX_HOLD, default 8, meaning the maximum number of consecutive cycles one grant may stay asserted; the legal range is 1..255.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port req, input, 16 bits: request from requester i on bit i, level-sensitive.
REQ-005 The block SHALL have port done, input, 1 bit: the current owner releases the grant.
REQ-006 The block SHALL have port grant_en, output, 1 bit: a grant is active.
REQ-007 The block SHALL have port grant_idx, output, 4 bits: the index of the granted requester.
REQ-008 The block SHALL have port grant, output, 16 bits: the one-hot decoded grant.
REQ-009 The block SHALL have port busy, output, 1 bit: high when the state is not IDLE.
REQ-010 The block SHALL have port forced_release, output, 1 bit: one-cycle pulse when a grant is revoked by the MAX_HOLD timeout.

Function
REQ-011 grant SHALL be produced by an instance of decoder_4to16 with enable=grant_en and in=grant_idx, so that grant=0 whenever grant_en=0.
REQ-012 The FSM SHALL have exactly three states: IDLE, GRANT and GAP.
REQ-013 Internal state SHALL be: ptr (4 bits, round-robin start index) and hold_cnt (8 bits).
REQ-014 In IDLE with req==0, the FSM SHALL stay in IDLE with grant_en=0.
REQ-015 In IDLE with req!=0, the winner SHALL be the first set bit searching ptr, ptr+1, ..., ptr+15, all modulo 16, with wrap from 15 to 0.
REQ-016 On that IDLE edge: grant_idx<=winner, grant_en<=1, hold_cnt<=0, next state GRANT; grant therefore appears one cycle after req is sampled.
REQ-017 In GRANT, the release condition SHALL be: req[grant_idx]==0, OR done==1, OR hold_cnt==MAX_HOLD-1.
REQ-018 In GRANT with the release condition false: hold_cnt<=hold_cnt+1, grant_en stays 1, grant_idx stays unchanged.
REQ-019 In GRANT with the release condition true: next state GAP, grant_en<=0, ptr<=grant_idx+1 mod 16 (15 wraps to 0).
REQ-020 A grant SHALL therefore last at most MAX_HOLD cycles.
REQ-021 forced_release SHALL pulse for exactly the one cycle spent in GAP, and only when the release was caused solely by the hold limit (req[grant_idx]==1 and done==0).
REQ-022 When done or a request drop coincides with the hold limit, forced_release SHALL stay 0.
REQ-023 GAP SHALL last exactly one cycle with grant_en=0 (break-before-make), then go to IDLE unconditionally.
REQ-024 The minimum spacing between grants SHALL therefore be 2 idle cycles (GAP, then IDLE).
REQ-025 grant_idx SHALL hold its last value while grant_en=0.
REQ-026 req changes during GAP SHALL be ignored; arbitration SHALL sample req only in IDLE.
REQ-027 done asserted outside GRANT SHALL be ignored.
REQ-028 Bits of req other than grant_idx SHALL have no effect during GRANT.
REQ-029 With MAX_HOLD=1, every grant SHALL last exactly one cycle.

Reset
REQ-030 While rst=1, the block SHALL immediately (asynchronously) force: state=IDLE, grant_en=0, grant=0, grant_idx=0, ptr=0, hold_cnt=0, busy=0, forced_release=0.
REQ-031 Reset asserted in GRANT or GAP SHALL abort the grant with no forced_release pulse.
REQ-032 The first arbitration after reset deassertion SHALL start at index 0.

Verification
REQ-033 Reset: rst=1 with req=16'hFFFF -> grant=16'h0000, grant_en=0, grant_idx=0, busy=0 with no clock edge required.
REQ-034 Single requester: req[5]=1 held, done=1 in the 3rd grant cycle -> grant=16'h0020 for 3 cycles, then 1 GAP cycle and 1 IDLE cycle, then req[5] is regranted; forced_release=0 throughout.
REQ-035 Timeout and wrap: req=16'hFFFF, MAX_HOLD=8, done=0 -> grants go 0,1,...,15,0 in order, each exactly 8 cycles, with a forced_release pulse after each grant.
REQ-036 Fairness: req[3] and req[12] held high after reset -> the grant sequence is 3,12,3,12 and neither requester is granted twice in a row.
REQ-037 Requester drop: req[7] falls in the 2nd grant cycle with MAX_HOLD=8 -> grant_en falls on the next edge and forced_release=0.
REQ-038 Reset mid-grant: rst pulsed while grant=16'h0400 -> grant=0 at once; after rst deasserts, the next arbitration with req=16'h0401 grants index 0.
